// File: rtl/imem_responder.sv
// Instruction-memory responder: program is written through the load port while in LOAD,
// then fetches are served with one-cycle latency in RUN, honouring the fetch-stage hold.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        hold,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_addr,
    output logic [1:0]  rsp_fault,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        ld_done,
    output logic        ld_err,
    output logic [15:0] ld_count,
    output logic        running
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t      state;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        ld_fire;
    logic [1:0]  req_fault;
    logic [1:0]  ld_fault;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] ld_idx;

    // Misalignment is checked on the raw address and takes priority over range.
    function automatic logic [1:0] fault_code(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        if (addr[1:0] != 2'b00) begin
            return 2'b01;
        end
        if ((off >> (AW + 2)) != '0) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return AW'(off >> 2);
    endfunction

    assign ld_ready  = (state == LOAD);
    assign running   = (state == RUN);
    assign req_ready = (state == RUN) && !hold;

    assign accept    = req_valid && req_ready;
    assign ld_fire   = ld_valid && ld_ready;
    assign req_fault = fault_code(req_addr);
    assign ld_fault  = fault_code(ld_addr);
    assign req_idx   = word_idx(req_addr);
    assign ld_idx    = word_idx(ld_addr);

    // Program storage is deliberately not reset so a reset mid-RUN keeps the image.
    always_ff @(posedge clk) begin
        if (!rst && ld_fire && (ld_fault == 2'b00)) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            rsp_valid <= 1'b0;
            rsp_data  <= NOP_INSTR;
            rsp_addr  <= '0;
            rsp_fault <= '0;
            ld_err    <= 1'b0;
            ld_count  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (ld_fire) begin
                        if (ld_fault != 2'b00) begin
                            ld_err <= 1'b1;
                        end else if (ld_count != '1) begin
                            ld_count <= ld_count + 16'd1;
                        end
                    end
                    if (ld_done) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (accept) begin
                            rsp_valid <= 1'b1;
                            rsp_addr  <= req_addr;
                            rsp_fault <= req_fault;
                            rsp_data  <= (req_fault == 2'b00) ? mem[req_idx] : NOP_INSTR;
                        end else begin
                            rsp_valid <= 1'b0;
                            rsp_data  <= NOP_INSTR;
                            rsp_fault <= '0;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder against a word-array reference model.
module tb_imem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        hold;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_err;
    logic [15:0] ld_count;
    logic        running;

    imem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .hold     (hold),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_addr (rsp_addr),
        .rsp_fault(rsp_fault),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .ld_count (ld_count),
        .running  (running)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference model: word array, list of loaded byte addresses, load statistics.
    logic [31:0] model_mem [DEPTH];
    int unsigned loaded_q [$];
    int unsigned exp_count;
    logic        exp_err;
    logic [66:0] exp_rsp;

    function automatic logic [1:0] exp_fault(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (addr % 4 != 0) return 2'b01;
        if (off >= 4 * DEPTH) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [66:0] exp_answer(input logic [31:0] addr);
        logic [1:0]  f;
        logic [31:0] off;
        f   = exp_fault(addr);
        off = addr - BASE;
        if (f != 2'b00) return {1'b1, NOP, addr, f};
        return {1'b1, model_mem[off / 4], addr, 2'b00};
    endfunction

    task automatic model_load(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        off = addr - BASE;
        if (exp_fault(addr) != 2'b00) begin
            exp_err = 1'b1;
        end else begin
            model_mem[off / 4] = data;
            exp_count++;
            loaded_q.push_back(addr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
        exp_rsp   = {1'b0, NOP, 32'h0, 2'b00};
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h expected %h", {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
        end
        n_cmp++;
        if ({ld_err, ld_count, running, req_ready, ld_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got err=%b cnt=%0d run=%b rr=%b lr=%b expected 0 0 0 0 1",
                     ld_err, ld_count, running, req_ready, ld_ready);
        end
    endtask

    task automatic test_load();
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            a = 32'(4 * i);
            d = $urandom;
            ld_valid = 1'b1; ld_addr = a; ld_data = d;
            model_load(a, d);
            step();
        end
        ld_valid = 1'b0;
        n_cmp++;
        if (ld_count !== 16'd4 || ld_err !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL load_four: got cnt=%0d err=%b run=%b expected 4 0 0", ld_count, ld_err, running);
        end
        for (int i = 0; i < 40; i++) begin
            a = (i == 0) ? BASE + 4 * (DEPTH - 1) : BASE + 4 * $urandom_range(4, DEPTH - 1);
            d = $urandom;
            ld_valid = 1'b1; ld_addr = a; ld_data = d;
            model_load(a, d);
            step();
        end
        // final write shares the cycle with ld_done and must still land
        a = BASE + 4 * $urandom_range(4, DEPTH - 1);
        d = $urandom;
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_done = 1'b1;
        model_load(a, d);
        step();
        ld_valid = 1'b0; ld_done = 1'b0;
        n_cmp++;
        if ({running, ld_ready, req_ready, ld_err} !== 4'b1010 || ld_count !== 16'(exp_count)) begin
            n_fail++;
            $display("FAIL load_done: got run=%b lr=%b rr=%b err=%b cnt=%0d expected 1 0 1 0 %0d",
                     running, ld_ready, req_ready, ld_err, ld_count, exp_count);
        end
    endtask

    task automatic test_single();
        req_valid = 1'b1; req_addr = 32'h4; hold = 1'b0;
        exp_rsp = exp_answer(32'h4);
        step();
        req_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
            n_fail++;
            $display("FAIL single_rsp: got %h expected %h", {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
        end
        exp_rsp = {1'b0, NOP, 32'h4, 2'b00};
        step();
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
            n_fail++;
            $display("FAIL idle_rsp: got %h expected %h", {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
        end
    endtask

    task automatic test_back_to_back_hold();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_addr = addrs[i];
            exp_rsp = exp_answer(addrs[i]);
            step();
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
                n_fail++;
                $display("FAIL b2b_rsp%0d: got %h expected %h", i, {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
            end
        end
        req_addr = addrs[2]; hold = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_ready: got %b expected 0", req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
                n_fail++;
                $display("FAIL hold_rsp%0d: got %h expected %h", i, {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
            end
        end
        hold = 1'b0;
        exp_rsp = exp_answer(addrs[2]);
        step();
        req_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
            n_fail++;
            $display("FAIL after_hold: got %h expected %h", {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
        end
        step();
    endtask

    task automatic test_faults();
        logic [31:0] tbl [6];
        tbl[0] = 32'h6;
        tbl[1] = BASE + 4 * DEPTH;
        tbl[2] = BASE + 4 * DEPTH + 2;
        tbl[3] = 32'hFFFF_FFFC;
        tbl[4] = BASE + 4 * (DEPTH - 1);
        tbl[5] = 32'h1001;
        hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_addr = tbl[i];
            exp_rsp = exp_answer(tbl[i]);
            step();
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
                n_fail++;
                $display("FAIL fault_%h: got %h expected %h", tbl[i], {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
            end
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_random_stream();
        logic [31:0] a;
        int unsigned sel;
        exp_rsp = {1'b0, NOP, rsp_addr, 2'b00};
        for (int i = 0; i < 400; i++) begin
            hold      = ($urandom % 4 == 0);
            req_valid = ($urandom % 3 != 0);
            sel = $urandom % 8;
            if (sel < 5)       a = loaded_q[$urandom % loaded_q.size()];
            else if (sel == 5) a = loaded_q[$urandom % loaded_q.size()] + $urandom_range(1, 3);
            else if (sel == 6) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 5000);
            else               a = $urandom;
            req_addr = a;
            if (!hold) begin
                if (req_valid) exp_rsp = exp_answer(a);
                else           exp_rsp = {1'b0, NOP, exp_rsp[33:2], 2'b00};
            end
            #1;
            n_cmp++;
            if (req_ready !== !hold) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", i, req_ready, !hold);
            end
            step();
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: got %h expected %h", i, {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
            end
        end
        req_valid = 1'b0; hold = 1'b0;
        step();
    endtask

    task automatic test_run_ignores_load();
        ld_valid = 1'b1; ld_addr = 32'h4; ld_data = ~model_mem[1]; ld_done = 1'b1;
        step();
        ld_addr = 32'h2;
        step();
        ld_valid = 1'b0; ld_done = 1'b0;
        n_cmp++;
        if ({running, ld_ready, ld_err} !== 3'b100 || ld_count !== 16'(exp_count)) begin
            n_fail++;
            $display("FAIL run_ld_ignored: got run=%b lr=%b err=%b cnt=%0d expected 1 0 0 %0d",
                     running, ld_ready, ld_err, ld_count, exp_count);
        end
        req_valid = 1'b1; req_addr = 32'h4;
        exp_rsp = exp_answer(32'h4);
        step();
        req_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
            n_fail++;
            $display("FAIL run_ld_data: got %h expected %h", {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
        end
    endtask

    task automatic test_reset_mid_run();
        req_valid = 1'b1; req_addr = 32'h8; hold = 1'b0;
        step();
        hold = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; req_valid = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
        exp_rsp   = {1'b0, NOP, 32'h0, 2'b00};
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
            n_fail++;
            $display("FAIL midrst_rsp: got %h expected %h", {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
        end
        n_cmp++;
        if ({running, ld_ready, req_ready, ld_err} !== 4'b0100 || ld_count !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_ctrl: got run=%b lr=%b rr=%b err=%b cnt=%0d expected 0 1 0 0 0",
                     running, ld_ready, req_ready, ld_err, ld_count);
        end
        hold = 1'b0;
    endtask

    task automatic test_load_errors();
        logic [31:0] bad [2];
        bad[0] = 32'h2;
        bad[1] = BASE + 4 * DEPTH;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_addr = bad[i]; ld_data = $urandom;
            model_load(bad[i], ld_data);
            step();
        end
        ld_valid = 1'b0;
        n_cmp++;
        if (ld_err !== exp_err || ld_count !== 16'(exp_count)) begin
            n_fail++;
            $display("FAIL ld_err: got err=%b cnt=%0d expected %b %0d", ld_err, ld_count, exp_err, exp_count);
        end
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * i);
            exp_rsp = exp_answer(32'(4 * i));
            step();
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_addr, rsp_fault} !== exp_rsp) begin
                n_fail++;
                $display("FAIL kept_word%0d: got %h expected %h", i, {rsp_valid, rsp_data, rsp_addr, rsp_fault}, exp_rsp);
            end
        end
        req_valid = 1'b0;
        step();
        n_cmp++;
        if (ld_err !== 1'b1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b run=%b expected 1 1", ld_err, running);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; hold = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_count = 0;
        exp_err   = 1'b0;
        test_reset();
        test_load();
        test_single();
        test_back_to_back_hold();
        test_faults();
        test_random_stream();
        test_run_ignores_load();
        test_reset_mid_run();
        test_load_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
